// File: rtl/cu_pkg.sv
// cu_pkg: shared state/class enums, opcode/func encodings and ALU opcodes
// for the multi-cycle control unit and its instruction decoder.
package cu_pkg;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } cu_state_t;

   typedef enum logic [3:0] {
      CLS_ILLEGAL,
      CLS_R_ALU,
      CLS_MULDIV,
      CLS_I_ALU,
      CLS_LOAD,
      CLS_STORE,
      CLS_LOAD_B,
      CLS_STORE_B,
      CLS_BRANCH,
      CLS_J,
      CLS_JAL,
      CLS_JR,
      CLS_SYSCALL
   } cu_class_t;

   localparam int ALU_CODE_W = 5;

   // Primary opcode field values
   localparam logic [5:0] OP_R_TYPE = 6'h00;
   localparam logic [5:0] OP_J      = 6'h02;
   localparam logic [5:0] OP_JAL    = 6'h03;
   localparam logic [5:0] OP_BEQ    = 6'h04;
   localparam logic [5:0] OP_BNE    = 6'h05;
   localparam logic [5:0] OP_BLEZ   = 6'h06;
   localparam logic [5:0] OP_BGTZ   = 6'h07;
   localparam logic [5:0] OP_ADDI   = 6'h08;
   localparam logic [5:0] OP_ADDIU  = 6'h09;
   localparam logic [5:0] OP_SLTI   = 6'h0A;
   localparam logic [5:0] OP_SLTIU  = 6'h0B;
   localparam logic [5:0] OP_ANDI   = 6'h0C;
   localparam logic [5:0] OP_ORI    = 6'h0D;
   localparam logic [5:0] OP_XORI   = 6'h0E;
   localparam logic [5:0] OP_LUI    = 6'h0F;
   localparam logic [5:0] OP_LB     = 6'h20;
   localparam logic [5:0] OP_LW     = 6'h23;
   localparam logic [5:0] OP_SB     = 6'h28;
   localparam logic [5:0] OP_SW     = 6'h2B;

   // R-type function field values
   localparam logic [5:0] FN_SLL     = 6'h00;
   localparam logic [5:0] FN_SRL     = 6'h02;
   localparam logic [5:0] FN_SRA     = 6'h03;
   localparam logic [5:0] FN_JR      = 6'h08;
   localparam logic [5:0] FN_SYSCALL = 6'h0C;
   localparam logic [5:0] FN_MULT    = 6'h18;
   localparam logic [5:0] FN_MULTU   = 6'h19;
   localparam logic [5:0] FN_DIV     = 6'h1A;
   localparam logic [5:0] FN_DIVU    = 6'h1B;
   localparam logic [5:0] FN_ADD     = 6'h20;
   localparam logic [5:0] FN_ADDU    = 6'h21;
   localparam logic [5:0] FN_SUB     = 6'h22;
   localparam logic [5:0] FN_SUBU    = 6'h23;
   localparam logic [5:0] FN_AND     = 6'h24;
   localparam logic [5:0] FN_OR      = 6'h25;
   localparam logic [5:0] FN_XOR     = 6'h26;
   localparam logic [5:0] FN_NOR     = 6'h27;
   localparam logic [5:0] FN_SLT     = 6'h2A;
   localparam logic [5:0] FN_SLTU    = 6'h2B;

   // Shared ALU opcodes; 0 means the ALU is idle
   localparam logic [ALU_CODE_W-1:0] ALU_NOP   = 5'd0;
   localparam logic [ALU_CODE_W-1:0] ALU_ADD   = 5'd1;
   localparam logic [ALU_CODE_W-1:0] ALU_SUB   = 5'd2;
   localparam logic [ALU_CODE_W-1:0] ALU_AND   = 5'd3;
   localparam logic [ALU_CODE_W-1:0] ALU_OR    = 5'd4;
   localparam logic [ALU_CODE_W-1:0] ALU_XOR   = 5'd5;
   localparam logic [ALU_CODE_W-1:0] ALU_NOR   = 5'd6;
   localparam logic [ALU_CODE_W-1:0] ALU_SLT   = 5'd7;
   localparam logic [ALU_CODE_W-1:0] ALU_SLTU  = 5'd8;
   localparam logic [ALU_CODE_W-1:0] ALU_SLL   = 5'd9;
   localparam logic [ALU_CODE_W-1:0] ALU_SRL   = 5'd10;
   localparam logic [ALU_CODE_W-1:0] ALU_SRA   = 5'd11;
   localparam logic [ALU_CODE_W-1:0] ALU_LUI   = 5'd12;
   localparam logic [ALU_CODE_W-1:0] ALU_MULT  = 5'd13;
   localparam logic [ALU_CODE_W-1:0] ALU_MULTU = 5'd14;
   localparam logic [ALU_CODE_W-1:0] ALU_DIV   = 5'd15;
   localparam logic [ALU_CODE_W-1:0] ALU_DIVU  = 5'd16;
   localparam logic [ALU_CODE_W-1:0] COMP_EQ   = 5'd17;
   localparam logic [ALU_CODE_W-1:0] COMP_NEQ  = 5'd18;
   localparam logic [ALU_CODE_W-1:0] COMP_GT   = 5'd19;
   localparam logic [ALU_CODE_W-1:0] COMP_LT   = 5'd20;

   function automatic logic is_load(input cu_class_t c);
      return (c == CLS_LOAD) || (c == CLS_LOAD_B);
   endfunction

   function automatic logic is_r_type(input cu_class_t c);
      return (c == CLS_R_ALU) || (c == CLS_MULDIV);
   endfunction

endpackage

// File: rtl/mc_cu_decode.sv
// mc_cu_decode: combinational opcode/func -> {instruction class, ALU opcode}.
// Optional macro CU_BYTE_MEM_EN makes LB/SB decode as byte load/store.
module mc_cu_decode
   import cu_pkg::*;
(
   input  logic [5:0]            opcode,
   input  logic [5:0]            func,
   output cu_class_t             cls,
   output logic [ALU_CODE_W-1:0] alu_op
);

   // Classify the instruction and select the ALU operation used in EXEC
   always_comb begin
      cls    = CLS_ILLEGAL;
      alu_op = ALU_NOP;
      case (opcode)
         OP_R_TYPE: begin
            case (func)
               FN_ADD, FN_ADDU: begin cls = CLS_R_ALU;  alu_op = ALU_ADD;   end
               FN_SUB, FN_SUBU: begin cls = CLS_R_ALU;  alu_op = ALU_SUB;   end
               FN_AND:          begin cls = CLS_R_ALU;  alu_op = ALU_AND;   end
               FN_OR:           begin cls = CLS_R_ALU;  alu_op = ALU_OR;    end
               FN_XOR:          begin cls = CLS_R_ALU;  alu_op = ALU_XOR;   end
               FN_NOR:          begin cls = CLS_R_ALU;  alu_op = ALU_NOR;   end
               FN_SLT:          begin cls = CLS_R_ALU;  alu_op = ALU_SLT;   end
               FN_SLTU:         begin cls = CLS_R_ALU;  alu_op = ALU_SLTU;  end
               FN_SLL:          begin cls = CLS_R_ALU;  alu_op = ALU_SLL;   end
               FN_SRL:          begin cls = CLS_R_ALU;  alu_op = ALU_SRL;   end
               FN_SRA:          begin cls = CLS_R_ALU;  alu_op = ALU_SRA;   end
               FN_MULT:         begin cls = CLS_MULDIV; alu_op = ALU_MULT;  end
               FN_MULTU:        begin cls = CLS_MULDIV; alu_op = ALU_MULTU; end
               FN_DIV:          begin cls = CLS_MULDIV; alu_op = ALU_DIV;   end
               FN_DIVU:         begin cls = CLS_MULDIV; alu_op = ALU_DIVU;  end
               FN_JR:           cls = CLS_JR;
               FN_SYSCALL:      cls = CLS_SYSCALL;
               default:         cls = CLS_ILLEGAL;
            endcase
         end
         OP_J:     cls = CLS_J;
         OP_JAL:   cls = CLS_JAL;
         OP_BEQ:   begin cls = CLS_BRANCH; alu_op = COMP_NEQ; end
         OP_BNE:   begin cls = CLS_BRANCH; alu_op = COMP_EQ;  end
         OP_BLEZ:  begin cls = CLS_BRANCH; alu_op = COMP_GT;  end
         OP_BGTZ:  begin cls = CLS_BRANCH; alu_op = COMP_LT;  end
         OP_ADDI, OP_ADDIU: begin cls = CLS_I_ALU; alu_op = ALU_ADD; end
         OP_SLTI:  begin cls = CLS_I_ALU; alu_op = ALU_SLT;  end
         OP_SLTIU: begin cls = CLS_I_ALU; alu_op = ALU_SLTU; end
         OP_ANDI:  begin cls = CLS_I_ALU; alu_op = ALU_AND;  end
         OP_ORI:   begin cls = CLS_I_ALU; alu_op = ALU_OR;   end
         OP_XORI:  begin cls = CLS_I_ALU; alu_op = ALU_XOR;  end
         OP_LUI:   begin cls = CLS_I_ALU; alu_op = ALU_LUI;  end
         OP_LW:    begin cls = CLS_LOAD;  alu_op = ALU_ADD;  end
         OP_SW:    begin cls = CLS_STORE; alu_op = ALU_ADD;  end
`ifdef CU_BYTE_MEM_EN
         OP_LB:    begin cls = CLS_LOAD_B;  alu_op = ALU_ADD; end
         OP_SB:    begin cls = CLS_STORE_B; alu_op = ALU_ADD; end
`endif
         default:  cls = CLS_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/mc_control_unit.sv
// mc_control_unit: multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM with a
// memory-ready handshake and an EXEC dwell counter for MULT/DIV.
// Optional macro CU_BYTE_MEM_EN adds LB/SB support and the byte_en output.
module mc_control_unit
   import cu_pkg::*;
#(
   parameter int ALU_OP_W      = 5,
   parameter int MULDIV_CYCLES = 32,
   parameter int LINK_REG      = 31
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [5:0]          opcode,
   input  logic [5:0]          func,
   input  logic                zero,
   input  logic                mem_ready,
   output logic                mem_read,
   output logic                mem_write,
   output logic                i_or_d,
   output logic                ir_write,
   output logic                pc_write,
   output logic                pc_write_cond,
   output logic                reg_dest,
   output logic                link,
   output logic                jump,
   output logic                jump_reg,
   output logic                branch,
   output logic                mem_to_reg,
   output logic                alu_src,
   output logic                reg_write,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic [4:0]          link_reg_idx,
   output logic [2:0]          state_o,
   output logic                halted,
`ifdef CU_BYTE_MEM_EN
   output logic                byte_en,
`endif
   output logic                illegal
);

   localparam int CNT_W = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;

   cu_state_t             state;
   cu_state_t             state_next;
   cu_class_t             cls_q;
   cu_class_t             dec_cls;
   logic [ALU_CODE_W-1:0] alu_op_q;
   logic [ALU_CODE_W-1:0] dec_alu_op;
   logic [CNT_W-1:0]      count;

   mc_cu_decode u_decode (
      .opcode (opcode),
      .func   (func),
      .cls    (dec_cls),
      .alu_op (dec_alu_op)
   );

   assign link_reg_idx = 5'(LINK_REG);
   assign state_o      = state;

   // State register; instruction class, ALU op and sticky flags are captured in DECODE
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_FETCH;
         cls_q    <= CLS_ILLEGAL;
         alu_op_q <= ALU_NOP;
         count    <= '0;
         halted   <= 1'b0;
         illegal  <= 1'b0;
      end else begin
         state <= state_next;
         if (state == S_DECODE) begin
            cls_q    <= dec_cls;
            alu_op_q <= dec_alu_op;
            if (dec_cls == CLS_MULDIV) count <= CNT_W'(MULDIV_CYCLES - 1);
            if (dec_cls == CLS_SYSCALL) halted <= 1'b1;
            if (dec_cls == CLS_ILLEGAL) illegal <= 1'b1;
         end else if ((state == S_EXEC) && (count != '0)) begin
            count <= count - 1'b1;
         end
      end
   end

   // Next-state logic and per-state datapath strobes
   always_comb begin
      state_next    = state;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      i_or_d        = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      reg_dest      = 1'b0;
      link          = 1'b0;
      jump          = 1'b0;
      jump_reg      = 1'b0;
      branch        = 1'b0;
      mem_to_reg    = 1'b0;
      alu_src       = 1'b0;
      reg_write     = 1'b0;
      alu_op        = '0;
`ifdef CU_BYTE_MEM_EN
      byte_en       = 1'b0;
`endif
      case (state)
         S_FETCH: begin
            mem_read = 1'b1;
            if (mem_ready) begin
               ir_write   = 1'b1;
               pc_write   = 1'b1;
               state_next = S_DECODE;
            end
         end
         S_DECODE: begin
            case (dec_cls)
               CLS_ILLEGAL: state_next = S_FETCH;
               CLS_SYSCALL: state_next = S_HALT;
               default:     state_next = S_EXEC;
            endcase
         end
         S_EXEC: begin
            alu_op = ALU_OP_W'(alu_op_q);
            case (cls_q)
               CLS_R_ALU: state_next = S_WB;
               CLS_MULDIV: begin
                  if (count == '0) state_next = S_WB;
               end
               CLS_I_ALU: begin
                  alu_src    = 1'b1;
                  state_next = S_WB;
               end
               CLS_LOAD, CLS_STORE, CLS_LOAD_B, CLS_STORE_B: begin
                  alu_src    = 1'b1;
                  state_next = S_MEM;
               end
               CLS_BRANCH: begin
                  branch        = 1'b1;
                  pc_write_cond = zero;
                  state_next    = S_FETCH;
               end
               CLS_J: begin
                  jump       = 1'b1;
                  pc_write   = 1'b1;
                  state_next = S_FETCH;
               end
               CLS_JAL: begin
                  jump       = 1'b1;
                  pc_write   = 1'b1;
                  reg_write  = 1'b1;
                  state_next = S_FETCH;
               end
               CLS_JR: begin
                  jump       = 1'b1;
                  jump_reg   = 1'b1;
                  pc_write   = 1'b1;
                  state_next = S_FETCH;
               end
               default: state_next = S_FETCH;
            endcase
         end
         S_MEM: begin
            i_or_d = 1'b1;
            if (is_load(cls_q)) mem_read = 1'b1;
            else                mem_write = 1'b1;
`ifdef CU_BYTE_MEM_EN
            byte_en = (cls_q == CLS_LOAD_B) || (cls_q == CLS_STORE_B);
`endif
            if (mem_ready) state_next = is_load(cls_q) ? S_WB : S_FETCH;
         end
         S_WB: begin
            reg_write  = 1'b1;
            link       = 1'b1;
            reg_dest   = is_r_type(cls_q);
            mem_to_reg = is_load(cls_q);
`ifdef CU_BYTE_MEM_EN
            byte_en    = (cls_q == CLS_LOAD_B);
`endif
            state_next = S_FETCH;
         end
         S_HALT:  state_next = S_HALT;
         default: state_next = S_FETCH;
      endcase
   end

endmodule

// File: tb/tb_mc_control_unit.sv
// tb_mc_control_unit: self-checking bench for mc_control_unit. A reference
// model expands each instruction into per-cycle expected outputs from the
// phase rules; directed, randomized and reset corner sequences are applied.
module tb_mc_control_unit;
   import cu_pkg::*;

   localparam int MDC  = 4;
   localparam int LINK = 31;

   localparam int P_FETCH = 0, P_DECODE = 1, P_EXEC = 2, P_MEM = 3, P_WB = 4, P_HALT = 5;
   localparam int K_ILL = 0, K_RALU = 1, K_MD = 2, K_IALU = 3, K_LW = 4, K_SW = 5, K_LB = 6,
                  K_SB = 7, K_BR = 8, K_J = 9, K_JAL = 10, K_JR = 11, K_SYS = 12;

   typedef struct packed {
      logic [2:0] st;
      logic       halted, illegal, byte_en;
      logic       mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond;
      logic       reg_dest, link, jump, jump_reg, branch, mem_to_reg, alu_src, reg_write;
      logic [4:0] alu_op;
      logic [4:0] link_idx;
   } outs_t;

   typedef struct {
      logic [5:0] opcode, func;
      logic       zero, mem_ready;
      outs_t      exp;
      string      name;
   } vec_t;

   typedef struct {
      logic [5:0] op, fn;
      logic       z;
      int         fw, mw;
      string      name;
   } instr_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] opcode, func;
   logic       zero, mem_ready;
   logic       mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond;
   logic       reg_dest, link, jump, jump_reg, branch, mem_to_reg, alu_src, reg_write;
   logic [4:0] alu_op, link_reg_idx;
   logic [2:0] state_o;
   logic       halted, illegal, byte_en;

   int checks = 0;
   int passes = 0;
   bit halted_m = 1'b0;
   bit illegal_m = 1'b0;
   vec_t   q[$];
   instr_t prog[$];

   logic [5:0] r_fns [18] = '{FN_SLL, FN_SRL, FN_SRA, FN_JR, FN_MULT, FN_MULTU, FN_DIV, FN_DIVU,
                              FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
                              FN_SLT, FN_SLTU};
   logic [5:0] i_ops [18] = '{OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_ADDI, OP_ADDIU,
                              OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LB, OP_LW,
                              OP_SB, OP_SW};

   always #5 clk = ~clk;

   mc_control_unit #(.ALU_OP_W(5), .MULDIV_CYCLES(MDC), .LINK_REG(LINK)) dut (
      .clk           (clk),
      .reset         (reset),
      .opcode        (opcode),
      .func          (func),
      .zero          (zero),
      .mem_ready     (mem_ready),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .i_or_d        (i_or_d),
      .ir_write      (ir_write),
      .pc_write      (pc_write),
      .pc_write_cond (pc_write_cond),
      .reg_dest      (reg_dest),
      .link          (link),
      .jump          (jump),
      .jump_reg      (jump_reg),
      .branch        (branch),
      .mem_to_reg    (mem_to_reg),
      .alu_src       (alu_src),
      .reg_write     (reg_write),
      .alu_op        (alu_op),
      .link_reg_idx  (link_reg_idx),
      .state_o       (state_o),
      .halted        (halted),
`ifdef CU_BYTE_MEM_EN
      .byte_en       (byte_en),
`endif
      .illegal       (illegal)
   );

`ifndef CU_BYTE_MEM_EN
   assign byte_en = 1'b0;
`endif

   // Instruction semantics table: kind of instruction and its EXEC ALU opcode
   function automatic void classify(input logic [5:0] op, input logic [5:0] fn,
                                    output int k, output logic [4:0] alu);
      k = K_ILL;
      alu = ALU_NOP;
      if (op == OP_R_TYPE) begin
         case (fn)
            FN_ADD, FN_ADDU: begin k = K_RALU; alu = ALU_ADD; end
            FN_SUB, FN_SUBU: begin k = K_RALU; alu = ALU_SUB; end
            FN_AND:  begin k = K_RALU; alu = ALU_AND;  end
            FN_OR:   begin k = K_RALU; alu = ALU_OR;   end
            FN_XOR:  begin k = K_RALU; alu = ALU_XOR;  end
            FN_NOR:  begin k = K_RALU; alu = ALU_NOR;  end
            FN_SLT:  begin k = K_RALU; alu = ALU_SLT;  end
            FN_SLTU: begin k = K_RALU; alu = ALU_SLTU; end
            FN_SLL:  begin k = K_RALU; alu = ALU_SLL;  end
            FN_SRL:  begin k = K_RALU; alu = ALU_SRL;  end
            FN_SRA:  begin k = K_RALU; alu = ALU_SRA;  end
            FN_MULT: begin k = K_MD; alu = ALU_MULT;  end
            FN_MULTU:begin k = K_MD; alu = ALU_MULTU; end
            FN_DIV:  begin k = K_MD; alu = ALU_DIV;   end
            FN_DIVU: begin k = K_MD; alu = ALU_DIVU;  end
            FN_JR:   k = K_JR;
            FN_SYSCALL: k = K_SYS;
            default: k = K_ILL;
         endcase
      end else begin
         case (op)
            OP_J:    k = K_J;
            OP_JAL:  k = K_JAL;
            OP_BEQ:  begin k = K_BR; alu = COMP_NEQ; end
            OP_BNE:  begin k = K_BR; alu = COMP_EQ;  end
            OP_BLEZ: begin k = K_BR; alu = COMP_GT;  end
            OP_BGTZ: begin k = K_BR; alu = COMP_LT;  end
            OP_ADDI, OP_ADDIU: begin k = K_IALU; alu = ALU_ADD; end
            OP_SLTI: begin k = K_IALU; alu = ALU_SLT;  end
            OP_SLTIU:begin k = K_IALU; alu = ALU_SLTU; end
            OP_ANDI: begin k = K_IALU; alu = ALU_AND;  end
            OP_ORI:  begin k = K_IALU; alu = ALU_OR;   end
            OP_XORI: begin k = K_IALU; alu = ALU_XOR;  end
            OP_LUI:  begin k = K_IALU; alu = ALU_LUI;  end
            OP_LW:   begin k = K_LW; alu = ALU_ADD; end
            OP_SW:   begin k = K_SW; alu = ALU_ADD; end
`ifdef CU_BYTE_MEM_EN
            OP_LB:   begin k = K_LB; alu = ALU_ADD; end
            OP_SB:   begin k = K_SB; alu = ALU_ADD; end
`endif
            default: k = K_ILL;
         endcase
      end
   endfunction

   // Expected outputs for one cycle in a given phase of an instruction
   function automatic outs_t expect_outs(input int ph, input int k, input logic [4:0] alu,
                                         input logic z, input logic mr);
      outs_t o;
      o          = '0;
      o.st       = 3'(ph);
      o.halted   = halted_m;
      o.illegal  = illegal_m;
      o.link_idx = 5'(LINK);
      case (ph)
         P_FETCH: begin
            o.mem_read = 1'b1;
            o.ir_write = mr;
            o.pc_write = mr;
         end
         P_EXEC: begin
            o.alu_op = alu;
            if (k inside {K_IALU, K_LW, K_SW, K_LB, K_SB}) o.alu_src = 1'b1;
            if (k == K_BR) begin o.branch = 1'b1; o.pc_write_cond = z; end
            if (k inside {K_J, K_JAL, K_JR}) begin o.jump = 1'b1; o.pc_write = 1'b1; end
            if (k == K_JAL) o.reg_write = 1'b1;
            if (k == K_JR) o.jump_reg = 1'b1;
         end
         P_MEM: begin
            o.i_or_d    = 1'b1;
            o.mem_read  = (k == K_LW) || (k == K_LB);
            o.mem_write = (k == K_SW) || (k == K_SB);
            o.byte_en   = (k == K_LB) || (k == K_SB);
         end
         P_WB: begin
            o.reg_write  = 1'b1;
            o.link       = 1'b1;
            o.reg_dest   = (k == K_RALU) || (k == K_MD);
            o.mem_to_reg = (k == K_LW) || (k == K_LB);
            o.byte_en    = (k == K_LB);
         end
         default: ;
      endcase
      return o;
   endfunction

   // Append one cycle; inputs irrelevant to the phase are randomized
   task automatic push(input string name, input int ph, input int k, input logic [4:0] alu,
                       input logic [5:0] op, input logic [5:0] fn, input logic z, input logic mr);
      vec_t v;
      v.opcode    = (ph == P_DECODE) ? op : 6'($urandom);
      v.func      = (ph == P_DECODE) ? fn : 6'($urandom);
      v.zero      = (ph == P_EXEC && k == K_BR) ? z : 1'($urandom);
      v.mem_ready = (ph == P_FETCH || ph == P_MEM) ? mr : 1'($urandom);
      v.exp       = expect_outs(ph, k, alu, v.zero, v.mem_ready);
      v.name      = $sformatf("%s/c%0d", name, q.size());
      q.push_back(v);
   endtask

   // Expand an instruction into its expected cycle-by-cycle behaviour
   task automatic expand(input instr_t in);
      int k;
      logic [4:0] alu;
      classify(in.op, in.fn, k, alu);
      for (int w = 0; w <= in.fw; w++) push(in.name, P_FETCH, k, alu, in.op, in.fn, in.z, w == in.fw);
      push(in.name, P_DECODE, k, alu, in.op, in.fn, in.z, 1'b0);
      if (k == K_ILL) begin illegal_m = 1'b1; return; end
      if (k == K_SYS) begin halted_m = 1'b1; return; end
      for (int c = 0; c < ((k == K_MD) ? MDC : 1); c++)
         push(in.name, P_EXEC, k, alu, in.op, in.fn, in.z, 1'b0);
      if (k inside {K_LW, K_SW, K_LB, K_SB})
         for (int w = 0; w <= in.mw; w++) push(in.name, P_MEM, k, alu, in.op, in.fn, in.z, w == in.mw);
      if (k inside {K_RALU, K_MD, K_IALU, K_LW, K_LB})
         push(in.name, P_WB, k, alu, in.op, in.fn, in.z, 1'b0);
   endtask

   function automatic instr_t mk(input logic [5:0] op, input logic [5:0] fn, input logic z,
                                 input int fw, input int mw, input string name);
      instr_t i;
      i.op = op; i.fn = fn; i.z = z; i.fw = fw; i.mw = mw; i.name = name;
      return i;
   endfunction

   task automatic applyStimulus(input vec_t v);
      opcode    = v.opcode;
      func      = v.func;
      zero      = v.zero;
      mem_ready = v.mem_ready;
   endtask

   task automatic checkOutput(input string name, input outs_t exp);
      outs_t act;
      @(negedge clk);
      act = {state_o, halted, illegal, byte_en, mem_read, mem_write, i_or_d, ir_write, pc_write,
             pc_write_cond, reg_dest, link, jump, jump_reg, branch, mem_to_reg, alu_src, reg_write,
             alu_op, link_reg_idx};
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s: got %b required %b", name, act, exp);
      @(posedge clk);
      #1;
   endtask

   task automatic runQueue();
      for (int i = 0; i < q.size(); i++) begin
         applyStimulus(q[i]);
         checkOutput(q[i].name, q[i].exp);
      end
      q.delete();
   endtask

   task automatic resetPulse();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset     = 1'b0;
      halted_m  = 1'b0;
      illegal_m = 1'b0;
   endtask

   initial begin
      instr_t ri;
      int k;
      logic [4:0] a;

      reset = 1'b1; opcode = '0; func = '0; zero = 1'b0; mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      prog.push_back(mk(6'h00, 6'h00, 1'b0, 1, 0, "reset_fetch_sll"));
      prog.push_back(mk(OP_R_TYPE, FN_ADD, 1'b0, 0, 0, "add"));
      prog.push_back(mk(OP_LW, 6'h00, 1'b0, 0, 3, "lw_wait3"));
      prog.push_back(mk(OP_BEQ, 6'h00, 1'b1, 0, 0, "beq_z1"));
      prog.push_back(mk(OP_BEQ, 6'h00, 1'b0, 0, 0, "beq_z0"));
      prog.push_back(mk(OP_R_TYPE, FN_MULT, 1'b0, 0, 0, "mult"));
      prog.push_back(mk(OP_BNE, 6'h11, 1'b1, 0, 0, "bne"));
      prog.push_back(mk(OP_BLEZ, 6'h22, 1'b0, 0, 0, "blez"));
      prog.push_back(mk(OP_BGTZ, 6'h33, 1'b1, 0, 0, "bgtz"));
      prog.push_back(mk(6'h3F, 6'h00, 1'b0, 0, 0, "illegal_3f"));
      prog.push_back(mk(OP_R_TYPE, FN_SUB, 1'b0, 0, 0, "sub_sticky"));
      prog.push_back(mk(OP_SW, 6'h00, 1'b0, 2, 1, "sw"));
      prog.push_back(mk(OP_J, 6'h00, 1'b0, 0, 0, "j"));
      prog.push_back(mk(OP_JAL, 6'h00, 1'b0, 0, 0, "jal"));
      prog.push_back(mk(OP_R_TYPE, FN_JR, 1'b0, 0, 0, "jr"));
      prog.push_back(mk(OP_ADDI, 6'h00, 1'b0, 0, 0, "addi"));
      prog.push_back(mk(OP_LUI, 6'h00, 1'b0, 0, 0, "lui"));
      prog.push_back(mk(OP_LB, 6'h00, 1'b0, 0, 1, "lb"));
      prog.push_back(mk(OP_SB, 6'h00, 1'b0, 0, 0, "sb"));
      prog.push_back(mk(OP_R_TYPE, FN_DIVU, 1'b0, 0, 0, "divu"));
      foreach (prog[i]) expand(prog[i]);
      runQueue();

      // SYSCALL then 20 cycles in HALT, then a reset pulse
      expand(mk(OP_R_TYPE, FN_SYSCALL, 1'b0, 0, 0, "syscall"));
      for (int c = 0; c < 20; c++) push("halt", P_HALT, K_SYS, ALU_NOP, 6'h0, 6'h0, 1'b0, 1'b0);
      runQueue();
      resetPulse();
      expand(mk(OP_R_TYPE, FN_OR, 1'b0, 0, 0, "or_after_halt"));
      runQueue();

      // Randomized instruction stream
      for (int n = 0; n < 80; n++) begin
         if ($urandom_range(0, 9) < 2) ri = mk(6'($urandom), 6'($urandom), 1'b0, 0, 0, "rnd");
         else if ($urandom_range(0, 1) == 0) ri = mk(OP_R_TYPE, r_fns[$urandom_range(0, 17)], 1'b0, 0, 0, "rnd");
         else ri = mk(i_ops[$urandom_range(0, 17)], 6'($urandom), 1'b0, 0, 0, "rnd");
         classify(ri.op, ri.fn, k, a);
         if (k == K_SYS) ri.fn = FN_ADD;
         ri.z  = 1'($urandom);
         ri.fw = $urandom_range(0, 2);
         ri.mw = $urandom_range(0, 3);
         ri.name = $sformatf("rnd%0d", n);
         expand(ri);
      end
      runQueue();

      // Reset asserted during the third MEM cycle of a stalled SW
      expand(mk(OP_SW, 6'h00, 1'b0, 0, 6, "sw_reset"));
      for (int i = 0; i < 5; i++) begin
         applyStimulus(q[i]);
         checkOutput(q[i].name, q[i].exp);
      end
      applyStimulus(q[5]);
      reset = 1'b1;
      checkOutput(q[5].name, q[5].exp);
      reset = 1'b0;
      halted_m = 1'b0;
      illegal_m = 1'b0;
      q.delete();
      expand(mk(OP_R_TYPE, FN_AND, 1'b0, 1, 0, "and_after_reset"));
      runQueue();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
- Multi-cycle successor to the single-cycle combinational control decoder.
- FSM sequences FETCH/DECODE/EXEC/MEM/WB per instruction, waits on a memory-ready handshake, and holds EXEC for iterative MULT/DIV.
- Sits between the instruction register and the shared-ALU/shared-memory multi-cycle datapath; emits per-state datapath strobes.

Parameters:
- ALU_OP_W, 5, width of alu_op; must be ≥ width of the shared ALU opcode constants.
- MULDIV_CYCLES, 32, EXEC dwell cycles for MULT/DIV (≥1).
- LINK_REG, 31, register index driven on link_reg_idx for JAL.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- opcode  in  6  instruction-register opcode field
- func  in  6  instruction-register function field
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- mem_read / mem_write  out  1  memory strobes; held until mem_ready
- i_or_d  out  1  0 = PC addresses memory (fetch), 1 = ALU result addresses memory
- ir_write  out  1  load instruction register
- pc_write  out  1  unconditional PC update
- pc_write_cond  out  1  PC update for a taken branch
- reg_dest, link, jump, jump_reg, branch, mem_to_reg, alu_src, reg_write  out  1 each  datapath selects/strobes (same meaning as the single-cycle decoder)
- alu_op  out  ALU_OP_W  shared ALU opcode
- link_reg_idx  out  5  equals LINK_REG
- state_o  out  3  current state encoding, for debug
- halted  out  1  sticky; set by SYSCALL
- illegal  out  1  sticky; set by an undecoded opcode/func

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- Reset (wins over everything, including mid-access): state=FETCH, all outputs 0, alu_op=0, muldiv counter=0, halted=0, illegal=0.
- Outputs are registered-state Moore decodes plus class decodes of the latched instruction class. Anything not asserted in a state is 0; no latch inference.
- FETCH: mem_read=1, i_or_d=0. When mem_ready=1: ir_write=1, pc_write=1 (PC+4), go to DECODE. Otherwise stay.
- DECODE: latch the instruction class from opcode/func.
  - Undecoded instruction: set illegal, go to FETCH.
  - SYSCALL: set halted, go to HALT.
  - Otherwise go to EXEC.
- EXEC, by class:
  - R-ALU: alu_op per func → WB.
  - MULT/DIV: counter loads MULDIV_CYCLES-1 on entry, stay until 0 → WB.
  - I-ALU: alu_src=1 → WB.
  - LW/SW: alu_src=1, alu_op=ADD → MEM.
  - Branch: branch=1, pc_write_cond=zero, with BEQ→COMP_NEQ, BNE→COMP_EQ, BLEZ→COMP_GT, BGTZ→COMP_LT → FETCH.
  - J: jump=1, pc_write=1 → FETCH.
  - JAL: jump=1, pc_write=1, reg_write=1, link=0 → FETCH.
  - JR: jump=1, jump_reg=1, pc_write=1 → FETCH.
- MEM: i_or_d=1, mem_read=1 (LW) or mem_write=1 (SW); hold until mem_ready. Then LW → WB, SW → FETCH.
- WB: reg_write=1, link=1.
  - R-type: reg_dest=1.
  - LW: mem_to_reg=1.
  - Then → FETCH.
- HALT: absorbing; all strobes 0 until reset.
- Latency with mem_ready tied 1:
  - R/I-ALU 4 cycles; LW 5; SW 4; branch/J/JAL/JR 3.
  - MULT/DIV: 3+MULDIV_CYCLES.
- mem_ready outside FETCH/MEM is ignored. opcode/func are sampled only in DECODE.

Optional Feature:
- Macro CU_BYTE_MEM_EN.
- Defined: LB/SB decode as load/store. Adds output byte_en (1 bit, reset 0), asserted in MEM for LB/SB; LB also asserts it in WB for sign-extension select. LB/SB timing equals LW/SW.
- Undefined: byte_en port absent; LB/SB are undecoded and set illegal.

Decomposition:
- Shared package cu_pkg holds:
  - state enum cu_state_t
  - instruction-class enum cu_class_t
  - opcode/func constants (existing R_TYPE/J/JAL/ADDi/... values)
  - ALU opcode constants
- Sub-module mc_cu_decode: combinational opcode/func → {class, alu_op}. Reused by the FSM in DECODE.

Test Plan:
- ADD (opcode 0, func 0x20), mem_ready=1 → states 0,1,2,4,0. reg_dest=reg_write=1 only in WB. alu_op=ALU_ADD in EXEC.
- LW with mem_ready low for 3 cycles in MEM → mem_read and i_or_d=1 held 3 cycles. Leaves on the 4th cycle; mem_to_reg=1 in WB; 8 cycles total.
- BEQ with zero=1, then zero=0 → pc_write_cond 1 then 0 in EXEC; alu_op=COMP_NEQ; 3 cycles each.
- MULT with MULDIV_CYCLES=4 → EXEC held exactly 4 cycles, then WB; 7 cycles total.
- SYSCALL → halted=1 from the cycle after DECODE, HALT holds 20 cycles. Reset pulse → FETCH; halted=0 next cycle.
- Opcode 0x3F → illegal=1 (sticky), returns to FETCH. Reset asserted mid-MEM of an SW → mem_write=0 next cycle, state=FETCH.
